// File: rtl/uart_tx_block64_pkg.sv
// Shared types and constants for the PRESENT-loop UART block transmitter.
// Build option: define UART_TX_PARITY_EN to add an even-parity bit to every frame.
package uart_tx_block64_pkg;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} tx_state_e;
  localparam int FRAME_BITS = 11;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} tx_state_e;
  localparam int FRAME_BITS = 10;
`endif

  // Clock cycles per line bit, truncated.
  function automatic int calc_bps_cnt(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

endpackage

// File: rtl/uart_tx_block64_byte_tx.sv
// Single-byte UART frame serializer (start, 8 data bits LSB-first, optional parity, stop).
// Build option: UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module uart_byte_tx
  import uart_tx_block64_pkg::*;
#(
  parameter int BPS_CNT = 434
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       i_start,
  input  logic [7:0] i_byte,
  input  logic       i_last,
  output logic       o_txd,
  output logic       o_byte_done,
  output logic       o_block_done
);

  localparam int BAUD_W = $clog2(BPS_CNT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BPS_CNT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(BPS_CNT - 2);

  tx_state_e         r_state;
  logic [BAUD_W-1:0] r_baud_cnt;
  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_shift;
  logic              r_txd;
  logic              r_byte_done;
  logic              r_block_done;
`ifdef UART_TX_PARITY_EN
  logic              r_parity;
`endif

  logic w_baud_end;
  assign w_baud_end = (r_baud_cnt == BAUD_LAST);

  // NOTE: every register in a clocked block is assigned with <= so all flops
  // update from the same pre-edge values, independent of statement order.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state      <= ST_IDLE;
      r_baud_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_txd        <= 1'b1;
      r_byte_done  <= 1'b0;
      r_block_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity     <= 1'b0;
`endif
    end else begin
      r_byte_done  <= 1'b0;
      r_block_done <= 1'b0;
      if (r_state != ST_IDLE)
        r_baud_cnt <= w_baud_end ? '0 : r_baud_cnt + 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_START;
            r_txd   <= 1'b0;
            r_shift <= i_byte;
`ifdef UART_TX_PARITY_EN
            r_parity <= ^i_byte;
`endif
          end
        end
        ST_START: begin
          if (w_baud_end) begin
            r_state   <= ST_DATA;
            r_txd     <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (w_baud_end) begin
            if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_state <= ST_PARITY;
              r_txd   <= r_parity;
`else
              r_state <= ST_STOP;
              r_txd   <= 1'b1;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_txd     <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (w_baud_end) begin
            r_state <= ST_STOP;
            r_txd   <= 1'b1;
          end
        end
`endif
        ST_STOP: begin
          // Done flags are set one cycle early so they are high in the final stop cycle.
          if (r_baud_cnt == BAUD_PRE) begin
            r_byte_done  <= 1'b1;
            r_block_done <= i_last;
          end
          if (w_baud_end) begin
            if (i_start) begin
              r_state <= ST_START;
              r_txd   <= 1'b0;
              r_shift <= i_byte;
`ifdef UART_TX_PARITY_EN
              r_parity <= ^i_byte;
`endif
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_txd        = r_txd;
  assign o_byte_done  = r_byte_done;
  assign o_block_done = r_block_done;

endmodule

// File: rtl/uart_tx_block64.sv
// Transmit stage of the PRESENT loop: sends the upper NUM_BYTES bytes of a 64-bit block, MSB byte first.
// Build option: UART_TX_PARITY_EN selects 8E1 frames instead of 8N1.
module uart_tx_block64
  import uart_tx_block64_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int UART_BPS  = 115200,
  parameter int NUM_BYTES = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        send_en,
  input  logic [63:0] send_data,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        uart_txd
);

  localparam int BPS_CNT = calc_bps_cnt(CLK_FREQ, UART_BPS);
  localparam int CNT_W   = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);

  generate
    if (BPS_CNT < 2) begin : g_bad_bps
      $error("uart_tx_block64: CLK_FREQ/UART_BPS must be at least 2");
    end
    if (NUM_BYTES < 1 || NUM_BYTES > 8) begin : g_bad_bytes
      $error("uart_tx_block64: NUM_BYTES must be in 1..8");
    end
  endgenerate

  logic             r_en_d0;
  logic             r_en_d1;
  logic             r_start_req;
  logic             r_busy;
  logic [CNT_W-1:0] r_byte_cnt;
  logic [63:0]      r_buf;

  logic       w_start_flag;
  logic       w_accept;
  logic       w_last_byte;
  logic       w_byte_done;
  logic       w_block_done;
  logic       w_next_byte;
  logic       w_byte_start;
  logic [7:0] w_byte_data;
  logic       w_txd;

  assign w_start_flag = r_en_d0 & ~r_en_d1;
  // A request arriving while a block is in flight is dropped, not queued.
  assign w_accept     = r_start_req & ~r_busy;
  assign w_last_byte  = (r_byte_cnt == LAST_BYTE);
  assign w_next_byte  = w_byte_done & ~w_last_byte;
  assign w_byte_start = w_accept | w_next_byte;
  assign w_byte_data  = w_accept ? send_data[63:56] : r_buf[63:56];

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_en_d0     <= 1'b0;
      r_en_d1     <= 1'b0;
      r_start_req <= 1'b0;
      r_busy      <= 1'b0;
      r_byte_cnt  <= '0;
    end else begin
      r_en_d0     <= send_en;
      r_en_d1     <= r_en_d0;
      r_start_req <= w_start_flag;
      if (w_accept) begin
        r_busy     <= 1'b1;
        r_byte_cnt <= '0;
      end else if (w_next_byte) begin
        r_byte_cnt <= r_byte_cnt + 1'b1;
      end else if (w_block_done) begin
        r_busy     <= 1'b0;
      end
    end
  end

  // NOTE: the block buffer is pure datapath and is always loaded before use,
  // so it carries no reset.
  always_ff @(posedge sys_clk) begin
    if (w_accept)
      r_buf <= {send_data[55:0], 8'h00};
    else if (w_next_byte)
      r_buf <= {r_buf[55:0], 8'h00};
  end

  uart_byte_tx #(
    .BPS_CNT (BPS_CNT)
  ) u_byte_tx (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .i_start      (w_byte_start),
    .i_byte       (w_byte_data),
    .i_last       (w_last_byte),
    .o_txd        (w_txd),
    .o_byte_done  (w_byte_done),
    .o_block_done (w_block_done)
  );

  assign tx_busy  = r_busy;
  assign tx_done  = w_block_done;
  assign uart_txd = w_txd;

endmodule

// File: tb/tb_uart_tx_block64.sv
// Directed bench for uart_tx_block64 at BPS_CNT=10, NUM_BYTES=8; honours UART_TX_PARITY_EN.
`timescale 1ns/1ps
module tb_uart_tx_block64;
  import uart_tx_block64_pkg::*;

  localparam int BIT_CYC = 10;
`ifdef UART_TX_PARITY_EN
  localparam int EXP_BUSY = 880;
`else
  localparam int EXP_BUSY = 800;
`endif
  localparam int CELL    = FRAME_BITS * BIT_CYC;
  localparam int MAX_CAP = 2400;

  typedef struct {
    logic [63:0] data;
    logic [63:0] alt;
    int          hold;
    int          retrig;
    int          tail;
    logic [63:0] exp;
  } vec_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        send_en;
  logic [63:0] send_data;
  logic        tx_busy;
  logic        tx_done;
  logic        uart_txd;

  int   n_checks = 0;
  int   n_errors = 0;
  logic cap_txd  [MAX_CAP];
  logic cap_busy [MAX_CAP];
  logic cap_done [MAX_CAP];
  vec_t vecs [4];

  uart_tx_block64 #(
    .CLK_FREQ  (1_000_000),
    .UART_BPS  (100_000),
    .NUM_BYTES (8)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .send_en   (send_en),
    .send_data (send_data),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .uart_txd  (uart_txd)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Raises send_en at the current negedge and records one sample per cycle.
  // Sample i is taken at the negedge after posedge k+i, where posedge k first sees send_en=1.
  task automatic run_block(input string name, input logic [63:0] data, input logic [63:0] exp,
                           input int hold, input int retrig, input logic [63:0] alt, input int tail);
    int          len;
    int          n_busy;
    int          n_done;
    int          done_at;
    int          base;
    logic [10:0] got_f;
    logic [10:0] exp_f;
    logic        glitch;
    logic        idle_ok;
    logic [7:0]  b;
    len       = EXP_BUSY + 2 + tail;
    send_data = data;
    send_en   = 1'b1;
    for (int i = 0; i < len; i++) begin
      @(negedge sys_clk);
      cap_txd[i]  = uart_txd;
      cap_busy[i] = tx_busy;
      cap_done[i] = tx_done;
      if (i == hold) send_en = 1'b0;
      if (i == retrig) begin
        send_en   = 1'b1;
        send_data = alt;
      end
    end
    send_en = 1'b0;

    check({name, " latency"}, {cap_txd[1], cap_busy[1], cap_txd[2], cap_busy[2]}, 4'b1001);

    n_busy  = 0;
    n_done  = 0;
    done_at = -1;
    for (int i = 0; i < len; i++) begin
      if (cap_busy[i] === 1'b1) n_busy++;
      if (cap_done[i] === 1'b1) begin
        n_done++;
        done_at = i;
      end
    end
    check({name, " busy cycles"}, 64'(n_busy), 64'(EXP_BUSY));
    check({name, " done pulse"}, {32'(n_done), 32'(done_at)}, {32'd1, 32'(EXP_BUSY + 1)});

    for (int j = 0; j < 8; j++) begin
      b      = exp[63 - 8*j -: 8];
      exp_f  = '0;
      exp_f[8:1] = b;
      if (FRAME_BITS == 11) begin
        exp_f[9]  = ^b;
        exp_f[10] = 1'b1;
      end else begin
        exp_f[9]  = 1'b1;
      end
      got_f  = '0;
      glitch = 1'b0;
      for (int f = 0; f < FRAME_BITS; f++) begin
        base     = 2 + j*CELL + f*BIT_CYC;
        got_f[f] = cap_txd[base + 5];
        for (int c = 0; c < BIT_CYC; c++)
          if (cap_txd[base + c] !== cap_txd[base + 5]) glitch = 1'b1;
      end
      check($sformatf("%s byte%0d frame", name, j), {glitch, got_f}, {1'b0, exp_f});
    end

    if (tail > 0) begin
      idle_ok = 1'b1;
      for (int i = EXP_BUSY + 2; i < len; i++)
        if (cap_txd[i] !== 1'b1 || cap_busy[i] !== 1'b0) idle_ok = 1'b0;
      check({name, " idle after block"}, idle_ok, 1'b1);
    end
  endtask

  initial begin
    vecs[0] = '{data: 64'h0123_4567_89AB_CDEF, alt: 64'h0, hold: 5, retrig: -1, tail: 20,
                exp: 64'h0123_4567_89AB_CDEF};
    vecs[1] = '{data: 64'hA5A5_0F0F_FF00_1234, alt: 64'h0, hold: 2000, retrig: -1, tail: 1300,
                exp: 64'hA5A5_0F0F_FF00_1234};
    vecs[2] = '{data: 64'h8000_0000_0000_0001, alt: 64'hFFFF_FFFF_FFFF_FFFF, hold: 5, retrig: 300,
                tail: 20, exp: 64'h8000_0000_0000_0001};
    vecs[3] = '{data: 64'h0355_AA00_FF3C_7E81, alt: 64'h0, hold: 5, retrig: -1, tail: 20,
                exp: 64'h0355_AA00_FF3C_7E81};

    sys_rst   = 1'b1;
    send_en   = 1'b0;
    send_data = 64'h0;
    repeat (3) @(negedge sys_clk);
    check("reset outputs", {uart_txd, tx_busy, tx_done}, 3'b100);
    sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("idle after reset", {uart_txd, tx_busy, tx_done}, 3'b100);

    // Basic, held strobe, mid-block request, parity-relevant byte 03.
    for (int v = 0; v < 4; v++) begin
      run_block($sformatf("vec%0d", v), vecs[v].data, vecs[v].exp, vecs[v].hold,
                vecs[v].retrig, vecs[v].alt, vecs[v].tail);
      repeat (3) @(negedge sys_clk);
    end

    // Back-to-back: second edge lands on the first cycle with tx_busy low.
    run_block("b2b_a", 64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788, 5, -1, 64'h0, 1);
    run_block("b2b_b", 64'hF0E1_D2C3_B4A5_9687, 64'hF0E1_D2C3_B4A5_9687, 5, -1, 64'h0, 20);
    repeat (3) @(negedge sys_clk);

    // Reset during data bit 4 of the third byte of an all-zero block.
    send_data = 64'h0;
    send_en   = 1'b1;
    for (int i = 0; i <= 2 + 2*CELL + 5*BIT_CYC + 3; i++) begin
      @(negedge sys_clk);
      if (i == 5) send_en = 1'b0;
    end
    check("rst: mid-frame line", {uart_txd, tx_busy}, 2'b01);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("rst: next clock", {uart_txd, tx_busy, tx_done}, 3'b100);
    sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("rst: stays idle", {uart_txd, tx_busy, tx_done}, 3'b100);
    run_block("after_rst", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5, -1, 64'h0, 20);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
